// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types for the CPU-to-Avalon load/store port.
// Access sizes, FSM states, read latency and alignment helpers.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int READ_LATENCY = 1;

  localparam logic [31:0] LAT_LAST =
    32'(READ_LATENCY - 1);

  // Encoding 3 is reserved and behaves as a word.
  function automatic size_e norm_size(
    input logic [1:0] s
  );
    return (s == 2'd3) ? SIZE_WORD : size_e'(s);
  endfunction

  function automatic logic is_misaligned(
    input size_e      s,
    input logic [1:0] a
  );
    return ((s == SIZE_HALF) && a[0]) ||
           ((s == SIZE_WORD) && (a != 2'd0));
  endfunction

endpackage

// File: rtl/mips_bus_lane.sv
// mips_bus_lane: byte-lane steering for little-endian loads/stores.
// In: size, signed, addr[1:0], wdata, rdata. Out: byteenable, lane wdata, extended rdata.
module mips_bus_lane
  import mips_bus_pkg::*;
(
  input  size_e       i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_rdata[31:16]
                            : i_rdata[15:0];

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    unique case (i_size)
      SIZE_BYTE: begin
        o_be    = 4'b0001 << i_addr;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_signed
          ? {{24{w_byte[7]}}, w_byte}
          : {24'd0, w_byte};
      end
      SIZE_HALF: begin
        o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = i_signed
          ? {{16{w_half[15]}}, w_half}
          : {16'd0, w_half};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mips_bus_interface.sv
// mips_bus_interface: one-at-a-time CPU load/store/fetch port onto an Avalon-MM master.
// CPU side: req/req_* in, busy/rsp_* out. Bus side: address/read/write/writedata/byteenable out, waitrequest/readdata in.
module mips_bus_interface
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        rsp_done,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  state_e      r_state;
  state_e      w_next;
  logic        r_we;
  size_e       r_size;
  logic        r_signed;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_cnt;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_address;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_writedata;
  logic [3:0]  r_be;

  size_e       w_req_size;
  logic        w_req_mis;
  size_e       w_ln_size;
  logic        w_ln_signed;
  logic [1:0]  w_ln_addr;
  logic [3:0]  w_ln_be;
  logic [31:0] w_ln_wdata;
  logic [31:0] w_ln_rdata;
  logic        w_accept;
  logic        w_timeout;
  logic        w_capture;

  assign w_req_size = norm_size(req_size);
  assign w_req_mis  =
    is_misaligned(w_req_size, req_addr[1:0]);

  // One lane unit: fed by the live request in
  // IDLE (store steering), by the latched
  // request afterwards (load extraction).
  assign w_ln_size   = (r_state == ST_IDLE)
                     ? w_req_size : r_size;
  assign w_ln_signed = (r_state == ST_IDLE)
                     ? req_signed : r_signed;
  assign w_ln_addr   = (r_state == ST_IDLE)
                     ? req_addr[1:0] : r_addr_lo;

  mips_bus_lane u_lane (
    .i_size   (w_ln_size),
    .i_signed (w_ln_signed),
    .i_addr   (w_ln_addr),
    .i_wdata  (req_wdata),
    .i_rdata  (readdata),
    .o_be     (w_ln_be),
    .o_wdata  (w_ln_wdata),
    .o_rdata  (w_ln_rdata)
  );

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_next = w_req_mis ? ST_DONE : ST_BUS;
        end
      end
      ST_BUS: begin
        w_accept  = !waitrequest;
        w_timeout = waitrequest &&
          (TIMEOUT_CYCLES != 0) &&
          ((r_cnt + 32'd1) == TIMEOUT_CYCLES);
        if (w_accept) begin
          w_next = r_we ? ST_DONE : ST_RESP;
        end else if (w_timeout) begin
          w_next = ST_DONE;
        end
      end
      ST_RESP: begin
        w_capture = (r_cnt == LAT_LAST);
        if (w_capture) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_size      <= SIZE_BYTE;
      r_signed    <= 1'b0;
      r_addr_lo   <= 2'd0;
      r_cnt       <= 32'd0;
      r_err       <= 1'b0;
      r_rdata     <= 32'd0;
      r_address   <= 32'd0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_writedata <= 32'd0;
      r_be        <= 4'd0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we      <= req_we;
            r_size    <= w_req_size;
            r_signed  <= req_signed;
            r_addr_lo <= req_addr[1:0];
            r_cnt     <= 32'd0;
            if (w_req_mis) begin
              r_err   <= 1'b1;
              r_rdata <= 32'd0;
            end else begin
              r_address   <= {req_addr[31:2], 2'b00};
              r_read      <= !req_we;
              r_write     <= req_we;
              r_be        <= req_we ? w_ln_be
                                    : 4'b1111;
              r_writedata <= req_we ? w_ln_wdata
                                    : 32'd0;
            end
          end
        end
        ST_BUS: begin
          if (w_accept || w_timeout) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_cnt   <= 32'd0;
            if (w_timeout) begin
              r_err   <= 1'b1;
              r_rdata <= 32'd0;
            end else if (r_we) begin
              r_err   <= 1'b0;
              r_rdata <= 32'd0;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_RESP: begin
          if (w_capture) begin
            r_err   <= 1'b0;
            r_rdata <= w_ln_rdata;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign rsp_done   = (r_state == ST_DONE);
  assign rsp_err    = r_err;
  assign rsp_rdata  = r_rdata;
  assign address    = r_address;
  assign read       = r_read;
  assign write      = r_write;
  assign writedata  = r_writedata;
  assign byteenable = r_be;

endmodule

// File: tb/tb_mips_bus_interface.sv
// tb_mips_bus_interface: scoreboard bench for mips_bus_interface.
// Driver queues expected bus/response items; negedge monitors pop and compare.
module tb_mips_bus_interface;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        req;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        rsp_done;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  mips_bus_interface #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .busy        (busy),
    .rsp_done    (rsp_done),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        chk_rd;
    int          edge_n;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cycles;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wait_cnt = 0;
  int wait_target = 0;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Avalon slave: fixed read latency 1, programmable stalls.
  always @(posedge clk) begin
    if ((read || write) && !waitrequest) begin
      if (write) begin
        for (int i = 0; i < 4; i++) begin
          if (byteenable[i])
            mem[address[5:2]][8*i +: 8] = writedata[8*i +: 8];
        end
      end else begin
        readdata = mem[address[5:2]];
      end
      wait_cnt = 0;
    end else if (read || write) begin
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    #1;
    waitrequest = (read || write) && (wait_cnt < wait_target);
  end

  // Response monitor.
  rsp_t er;
  always @(negedge clk) begin
    if (rsp_done) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        er = rsp_q.pop_front();
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, er.err});
        if (er.chk_rd)
          chk("rsp_rdata", rsp_rdata, er.rdata);
        chk("rsp_edge", 32'(cyc), 32'(er.edge_n));
      end
    end
  end

  // Bus monitor: every active cycle must match the pending item.
  bus_t eb;
  logic prev_act = 1'b0;
  int   n_act = 0;
  always @(negedge clk) begin
    if (read && write)
      chk("rd_wr_both", 32'd1, 32'd0);
    if (read || write) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", 32'd1, 32'd0);
      end else begin
        eb = bus_q[0];
        chk("bus_write", {31'd0, write}, {31'd0, eb.we});
        chk("bus_addr", address, eb.addr);
        chk("bus_be", {28'd0, byteenable}, {28'd0, eb.be});
        if (eb.we)
          chk("bus_wdata", writedata, eb.wdata);
      end
      n_act++;
    end else if (prev_act) begin
      if (bus_q.size() != 0) begin
        eb = bus_q.pop_front();
        if (eb.cycles >= 0)
          chk("bus_held", 32'(n_act), 32'(eb.cycles));
      end
      n_act = 0;
    end
    prev_act = read || write;
  end

  function automatic logic [1:0] nsz(input logic [1:0] s);
    return (s == 2'd3) ? 2'd2 : s;
  endfunction

  function automatic logic misal(input logic [1:0] s,
                                 input logic [1:0] a);
    return (s == 2'd1 && a[0]) || (s == 2'd2 && a != 2'd0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] s,
                                      input logic [1:0] a);
    if (s == 2'd0) return 4'(4'b0001 << a);
    if (s == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] s,
                                       input logic [31:0] d);
    if (s == 2'd0) return {4{d[7:0]}};
    if (s == 2'd1) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [1:0] s,
                                       input logic sg,
                                       input logic [1:0] a,
                                       input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * a);
    if (s == 2'd0)
      return sg ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
    if (s == 2'd1)
      return sg ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
    return w;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  // Issue one access; hand=1 uses the hand-computed err/rdata.
  task automatic access(input logic we,
                        input logic [1:0] sz,
                        input logic sg,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input int waits,
                        input logic hand,
                        input logic [31:0] h_rd,
                        input logic h_err);
    rsp_t r;
    bus_t b;
    logic [1:0] s;
    int k;
    wait_idle();
    s = nsz(sz);
    k = cyc + 1;
    b.we = we;
    b.addr = {addr[31:2], 2'b00};
    b.be = we ? m_be(s, addr[1:0]) : 4'b1111;
    b.wdata = m_wd(s, wd);
    b.cycles = waits + 1;
    r.chk_rd = 1'b1;
    if (misal(s, addr[1:0])) begin
      r.err = 1'b1;
      r.rdata = 32'd0;
      r.edge_n = k;
    end else if (waits >= TO) begin
      r.err = 1'b1;
      r.rdata = 32'd0;
      r.edge_n = k + TO;
      b.cycles = TO;
      bus_q.push_back(b);
    end else if (we) begin
      r.err = 1'b0;
      r.rdata = 32'd0;
      r.chk_rd = 1'b0;
      r.edge_n = k + 1 + waits;
      for (int i = 0; i < 4; i++)
        if (b.be[i])
          ref_mem[addr[5:2]][8*i +: 8] = b.wdata[8*i +: 8];
      bus_q.push_back(b);
    end else begin
      r.err = 1'b0;
      r.rdata = m_ld(s, sg, addr[1:0], ref_mem[addr[5:2]]);
      r.edge_n = k + 2 + waits;
      bus_q.push_back(b);
    end
    if (hand) begin
      r.err = h_err;
      r.rdata = h_rd;
    end
    rsp_q.push_back(r);
    wait_target = waits;
    req = 1'b1;
    req_we = we;
    req_size = sz;
    req_signed = sg;
    req_addr = addr;
    req_wdata = wd;
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus_t b;
    int t;
    reset = 1'b0;
    req = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_signed = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    waitrequest = 1'b0;
    readdata = 32'd0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0101_0101 * i ^ 32'h5A00_C300;
    mem[0] = 32'h8001_FFFE;
    mem[3] = 32'h1122_3344;
    mem[4] = 32'hDEAD_BEEF;
    for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, rsp_done}, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_wdata", writedata, 32'd0);
    chk("rst_be", {28'd0, byteenable}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    access(0, 2'd2, 0, 32'h10, 32'h0, 0, 1, 32'hDEAD_BEEF, 0);
    access(1, 2'd0, 0, 32'h0D, 32'hA5, 3, 1, 32'h0, 0);
    access(0, 2'd2, 0, 32'h0C, 32'h0, 0, 1, 32'h1122_A544, 0);
    access(0, 2'd1, 1, 32'h02, 32'h0, 0, 1, 32'hFFFF_8001, 0);
    access(0, 2'd1, 0, 32'h02, 32'h0, 1, 1, 32'h0000_8001, 0);
    access(0, 2'd1, 1, 32'h00, 32'h0, 0, 1, 32'hFFFF_FFFE, 0);
    access(0, 2'd0, 1, 32'h03, 32'h0, 2, 1, 32'hFFFF_FF80, 0);
    access(0, 2'd0, 0, 32'h01, 32'h0, 0, 1, 32'h0000_00FF, 0);
    access(0, 2'd2, 0, 32'h06, 32'h0, 0, 1, 32'h0, 1);
    access(1, 2'd1, 0, 32'h05, 32'h1234, 0, 1, 32'h0, 1);
    access(1, 2'd1, 0, 32'h22, 32'h0000_BEEF, 1, 0, 32'h0, 0);
    access(0, 2'd3, 0, 32'h10, 32'h0, 0, 1, 32'hDEAD_BEEF, 0);
    access(0, 2'd2, 0, 32'h14, 32'h0, 100, 1, 32'h0, 1);

    wait_idle();
    b.we = 1'b0;
    b.addr = 32'h20;
    b.be = 4'b1111;
    b.wdata = 32'd0;
    b.cycles = -1;
    bus_q.push_back(b);
    wait_target = 100;
    req = 1'b1;
    req_we = 1'b0;
    req_size = 2'd2;
    req_addr = 32'h20;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("rst_pre_read", {31'd0, read}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_read", {31'd0, read}, 32'd0);
    chk("arst_write", {31'd0, write}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, rsp_done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_target = 0;
    @(negedge clk);
    access(0, 2'd2, 0, 32'h10, 32'h0, 0, 1, 32'hDEAD_BEEF, 0);

    for (int i = 0; i < 200; i++) begin
      access(1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             32'($urandom_range(0, 63)),
             $urandom,
             $urandom_range(0, 3),
             0, 32'h0, 0);
    end

    t = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0 || busy)
           && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
    chk("drain_bus_q", 32'(bus_q.size()), 32'd0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_bus_interface.md
Name: mips_bus_interface

Overview:
- Load/store/fetch port between the MIPS CPU datapath and the Avalon memory-mapped master bus.
- Takes one CPU-side request at a time and drives a word-aligned Avalon read or write, honouring waitrequest.
- Generates byteenable and lane-aligned writedata for SB/SH/SW.
- Extracts and sign- or zero-extends LB/LBU/LH/LHU/LW data and returns it with a one-cycle done pulse.

Parameters:
- TIMEOUT_CYCLES, 0: cycles of continuous waitrequest tolerated before the access is aborted with an error; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  1  CPU access request, sampled only in IDLE
- req_we  in  1  1=store, 0=load/fetch
- req_size  in  2  0=byte, 1=half, 2=word; 3 is reserved and treated as word
- req_signed  in  1  sign-extend load result (byte/half only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- busy  out  1  high whenever state is not IDLE
- rsp_done  out  1  one-cycle completion pulse
- rsp_err  out  1  valid with rsp_done: misalignment or timeout
- rsp_rdata  out  32  extended load data, valid with rsp_done
- address  out  32  Avalon address, always {addr[31:2],2'b00}
- read  out  1  Avalon read
- write  out  1  Avalon write
- waitrequest  in  1  Avalon stall
- writedata  out  32  Avalon write data
- byteenable  out  4  Avalon lane enables
- readdata  in  32  Avalon read data

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, timeout counter=0.
  - All outputs are 0: busy, rsp_done, rsp_err, rsp_rdata, address, read, write, writedata, byteenable.
  - An in-flight bus cycle is dropped immediately; no done pulse follows.
- States: IDLE, BUS, RESP, DONE.
- IDLE:
  - On req=1 at a rising edge, latch we/size/signed/addr[1:0].
  - If misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to DONE with err=1. No bus activity.
  - Otherwise go to BUS, registering address, read=!we, write=we, byteenable and writedata.
- BUS:
  - Outputs are held stable while waitrequest=1.
  - The transfer is accepted at the edge where waitrequest=0. On that edge read/write drop to 0.
  - After acceptance, a write goes to DONE and a read goes to RESP.
  - Each edge with waitrequest=1 increments the timeout counter. If TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES, deassert read/write and go to DONE with err=1.
- RESP: fixed read latency of 1. readdata is captured at the next edge, extracted, and the FSM goes to DONE.
- DONE: rsp_done=1 for exactly one cycle, then return to IDLE. req is ignored in DONE and in every non-IDLE state.
- Latency, from the req edge k:
  - bus signals visible after k;
  - write with no wait: rsp_done in cycle k+2;
  - read with no wait: rsp_done in cycle k+3;
  - each waitrequest cycle adds 1.
- Lanes are little-endian; lane i is bits [8i+7:8i].
  - byte: byteenable=1<<addr[1:0]; writedata = byte replicated x4.
  - half: byteenable = addr[1] ? 4'b1100 : 4'b0011; writedata = half replicated x2.
  - word: byteenable=4'b1111; writedata=req_wdata.
  - Reads always drive byteenable=4'b1111.
- Load extraction: select the lane or half by addr[1:0], then sign-extend when req_signed=1, else zero-extend. Word loads ignore req_signed.
- rsp_rdata and rsp_err hold their values until the next rsp_done. rsp_rdata=0 on error.
- read and write are never asserted together. address and byteenable are stable for the whole BUS state.

Decomposition:
- Package mips_bus_pkg:
  - access-size enum (SIZE_BYTE/SIZE_HALF/SIZE_WORD);
  - FSM state enum;
  - READ_LATENCY=1 constant.
- Sub-module mips_bus_lane (combinational), shared with later units:
  - inputs: size, signed, addr[1:0], wdata, rdata;
  - outputs: byteenable, lane-aligned writedata, extended load data.

Test Plan:
- Word load, addr=0x10, waitrequest=0, memory word[4]=0xDEADBEEF -> read=1 one cycle, address=0x10, byteenable=1111; rsp_done at k+3 with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte store, addr=0x0D, wdata=0x000000A5, waitrequest=1 for 3 cycles -> write held 4 cycles, byteenable=0010, writedata=0xA5A5A5A5, address=0x0C; memory word becomes 0x????A5?? with other bytes unchanged; rsp_done at k+5.
- Signed/unsigned half loads of 0x8001FFFE at addr 0x2 -> LH gives 0xFFFF8001, LHU gives 0x00008001; at addr 0x0, LH gives 0xFFFFFFFE.
- Misaligned word load at addr 0x6 -> read/write never asserted; rsp_done at k+1 with rsp_err=1, rsp_rdata=0.
- TIMEOUT_CYCLES=4, waitrequest stuck high -> read drops after 4 stall edges; rsp_done with rsp_err=1. Random-waitrequest soak: 200 random accesses checked against a reference memory model.
- reset=0 asserted mid-BUS -> read/write/busy go to 0 asynchronously with no rsp_done; a new req after reset release completes normally.
